bcd_conv_arbiter: RTL and testbench

- Sequential binary-to-BCD controller, shared between two requesters, e.g. the operand path and the result path feeding the 7-segment display.
- Arbitrates requests round-robin and captures the winner's binary word.
- Runs an iterative shift-and-add-3 (double-dabble) conversion, one bit per clock.
- Returns packed BCD digits with a one-cycle done strobe tagged with the requester ID.

---
 rtl/bcd_conv_arbiter.sv | 122 ++++++++++++
 tb/tb_bcd_conv_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_conv_arbiter.sv
// Two-requester round-robin binary-to-BCD converter (double-dabble, one bit per clock).
// Define BCD_OVF_EN to add a guard digit and a live ovf flag; otherwise ovf is tied low.
module bcd_conv_arbiter #(
  parameter int unsigned WIDTH_BIN = 13,
  parameter int unsigned DIGITS    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic [WIDTH_BIN-1:0]  bin0,
  input  logic                  req1,
  input  logic [WIDTH_BIN-1:0]  bin1,
  output logic                  ack0,
  output logic                  ack1,
  output logic                  busy,
  output logic                  done,
  output logic                  done_id,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

`ifdef BCD_OVF_EN
  localparam int unsigned ACC_DIGITS = DIGITS + 1;
`else
  localparam int unsigned ACC_DIGITS = DIGITS;
`endif
  localparam int unsigned ACC_W = 4 * ACC_DIGITS;
  localparam int unsigned CNT_W = $clog2(WIDTH_BIN + 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e               state;
  logic [ACC_W-1:0]     acc;
  logic [ACC_W-1:0]     acc_adj;
  logic [WIDTH_BIN-1:0] sr;
  logic [CNT_W-1:0]     cnt;
  logic                 last_grant;
  logic                 grant1;

  // On a tie the requester that did not win last time gets the slot.
  assign grant1 = req1 & (~req0 | ~last_grant);

  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < int'(ACC_DIGITS); i++) begin
      if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
  end

`ifdef BCD_OVF_EN
  logic lost;
`else
  logic unused_top;
  assign unused_top = acc_adj[ACC_W-1];
  assign ovf        = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StIdle;
      acc        <= '0;
      sr         <= '0;
      cnt        <= '0;
      last_grant <= 1'b1;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      done_id    <= 1'b0;
      bcd        <= '0;
`ifdef BCD_OVF_EN
      lost       <= 1'b0;
      ovf        <= 1'b0;
`endif
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (req0 || req1) begin
            sr         <= grant1 ? bin1 : bin0;
            acc        <= '0;
            cnt        <= '0;
            last_grant <= grant1;
            done_id    <= grant1;
            ack0       <= ~grant1;
            ack1       <= grant1;
            busy       <= 1'b1;
            state      <= StShift;
`ifdef BCD_OVF_EN
            lost       <= 1'b0;
`endif
          end
        end
        StShift: begin
          if (cnt == CNT_W'(WIDTH_BIN)) begin
            state <= StDone;
            done  <= 1'b1;
            bcd   <= acc[4*DIGITS-1:0];
`ifdef BCD_OVF_EN
            ovf   <= (acc[ACC_W-1:4*DIGITS] != '0) | lost;
`endif
          end else begin
            acc <= {acc_adj[ACC_W-2:0], sr[WIDTH_BIN-1]};
            sr  <= {sr[WIDTH_BIN-2:0], 1'b0};
            cnt <= cnt + CNT_W'(1);
`ifdef BCD_OVF_EN
            lost <= lost | acc_adj[ACC_W-1];
`endif
          end
        end
        StDone: begin
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Self-checking bench for bcd_conv_arbiter: directed scenarios plus randomized
// request patterns compared against a decimal-arithmetic reference model.
module tb_bcd_conv_arbiter;
  localparam int unsigned W  = 13;
  localparam int unsigned D  = 4;
  localparam int unsigned BW = 4 * D;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0]  bin0 = '0, bin1 = '0;
  logic          ack0, ack1, busy, done, done_id, ovf;
  logic [BW-1:0] bcd;

  int checks = 0;
  int failures = 0;

  // Observations gathered by run_pattern
  int            ack_t[2];
  logic          busy_at_ack, busy_end;
  logic          ev_id[$];
  logic [BW-1:0] ev_bcd[$];
  logic          ev_ovf[$];
  int            ev_t[$];

  bcd_conv_arbiter #(.WIDTH_BIN(W), .DIGITS(D)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .bin0(bin0), .req1(req1), .bin1(bin1),
    .ack0(ack0), .ack1(ack1), .busy(busy), .done(done),
    .done_id(done_id), .bcd(bcd), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [BW-1:0] model_bcd(input int unsigned v);
    logic [BW-1:0] r;
    int unsigned t;
    t = v;
    for (int i = 0; i < int'(D); i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic model_ovf(input int unsigned v);
`ifdef BCD_OVF_EN
    return v >= 10 ** D;
`else
    return (v & 0) != 0;
`endif
  endfunction

  // Drives one request pattern from a negedge and records what the DUT does.
  task automatic run_pattern(input bit r0, input logic [W-1:0] v0, input bit r1,
                             input logic [W-1:0] v1, input int late1);
    int want;
    ev_id.delete(); ev_bcd.delete(); ev_ovf.delete(); ev_t.delete();
    ack_t[0] = -1; ack_t[1] = -1; busy_at_ack = 1'b0;
    want = int'(r0) + int'(r1);
    if (r0) begin req0 = 1'b1; bin0 = v0; end
    if (r1 && late1 == 0) begin req1 = 1'b1; bin1 = v1; end
    for (int n = 1; n <= 80 && ev_id.size() < want; n++) begin
      @(negedge clk);
      if (ack0 && ack_t[0] < 0) begin ack_t[0] = n; req0 = 1'b0; busy_at_ack = busy; end
      if (ack1 && ack_t[1] < 0) begin ack_t[1] = n; req1 = 1'b0; end
      if (done) begin
        ev_id.push_back(done_id); ev_bcd.push_back(bcd);
        ev_ovf.push_back(ovf); ev_t.push_back(n);
      end
      if (r1 && late1 != 0 && n == late1) begin req1 = 1'b1; bin1 = v1; end
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    busy_end = busy;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({ack0, ack1, busy, done, done_id, ovf, bcd} !== '0) begin
      failures++;
      $display("FAIL reset_state: got %b/%b/%b/%b/%b/%b/%h want all zero",
               ack0, ack1, busy, done, done_id, ovf, bcd);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    bit           ids[3]  = '{1'b0, 1'b1, 1'b1};
    int unsigned  vals[3] = '{1234, 0, 8191};
    logic [BW-1:0] hold;
    for (int k = 0; k < 3; k++) begin
      run_pattern(!ids[k], W'(vals[k]), ids[k], W'(vals[k]), 0);
      checks++;
      if (ack_t[ids[k]] !== 1 || ack_t[!ids[k]] !== -1) begin
        failures++;
        $display("FAIL single_ack[%0d]: got ack0@%0d ack1@%0d want ack%0d@1 only",
                 k, ack_t[0], ack_t[1], ids[k]);
      end
      checks++;
      if (ev_id.size() != 1) begin
        failures++;
        $display("FAIL single_done_count[%0d]: got %0d want 1", k, ev_id.size());
      end else begin
        checks++;
        if (ev_bcd[0] !== model_bcd(vals[k]) || ev_id[0] !== ids[k] ||
            ev_ovf[0] !== model_ovf(vals[k]) || ev_t[0] != 15) begin
          failures++;
          $display("FAIL single_result[%0d]: got bcd=%h id=%b ovf=%b t=%0d want %h/%b/%b/15",
                   k, ev_bcd[0], ev_id[0], ev_ovf[0], ev_t[0], model_bcd(vals[k]), ids[k],
                   model_ovf(vals[k]));
        end
      end
      checks++;
      if (busy_at_ack !== (ids[k] ? 1'b0 : 1'b1) && !ids[k] || busy_end !== 1'b0) begin
        failures++;
        $display("FAIL single_busy[%0d]: got at_ack=%b end=%b want 1/0", k, busy_at_ack, busy_end);
      end
      hold = model_bcd(vals[k]);
      repeat (3) @(negedge clk);
      checks++;
      if (bcd !== hold) begin
        failures++;
        $display("FAIL bcd_hold[%0d]: got %h want %h", k, bcd, hold);
      end
    end
  endtask

  task automatic test_tie();
    int unsigned a, b;
    for (int round = 0; round < 2; round++) begin
      a = (round == 0) ? 42  : $urandom_range(0, 2**W - 1);
      b = (round == 0) ? 907 : $urandom_range(0, 2**W - 1);
      run_pattern(1'b1, W'(a), 1'b1, W'(b), 0);
      checks++;
      if (ack_t[0] != 1 || ack_t[1] != 17) begin
        failures++;
        $display("FAIL tie_ack[%0d]: got ack0@%0d ack1@%0d want 1/17", round, ack_t[0], ack_t[1]);
      end
      checks++;
      if (ev_id.size() != 2) begin
        failures++;
        $display("FAIL tie_done_count[%0d]: got %0d want 2", round, ev_id.size());
      end else begin
        checks++;
        if (ev_id[0] !== 1'b0 || ev_bcd[0] !== model_bcd(a) || ev_t[0] != 15 ||
            ev_id[1] !== 1'b1 || ev_bcd[1] !== model_bcd(b) || ev_t[1] != 31) begin
          failures++;
          $display("FAIL tie_order[%0d]: got %b:%h@%0d %b:%h@%0d want 0:%h@15 1:%h@31", round,
                   ev_id[0], ev_bcd[0], ev_t[0], ev_id[1], ev_bcd[1], ev_t[1],
                   model_bcd(a), model_bcd(b));
        end
      end
    end
  endtask

  task automatic test_late_request();
    int unsigned a, b;
    a = $urandom_range(0, 2**W - 1);
    b = $urandom_range(0, 2**W - 1);
    run_pattern(1'b1, W'(a), 1'b1, W'(b), 5);
    checks++;
    if (ack_t[0] != 1 || ack_t[1] != 17) begin
      failures++;
      $display("FAIL late_ack: got ack0@%0d ack1@%0d want 1/17", ack_t[0], ack_t[1]);
    end
    checks++;
    if (ev_id.size() != 2 || ev_bcd[1] !== model_bcd(b) || ev_id[1] !== 1'b1) begin
      failures++;
      $display("FAIL late_result: got %0d dones want 2 ending id1 bcd=%h", ev_id.size(),
               model_bcd(b));
    end
  endtask

  task automatic test_reset_mid();
    int ndone;
    req0 = 1'b1; bin0 = W'(777);
    @(negedge clk);
    req0 = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({ack0, ack1, busy, done, done_id, ovf, bcd} !== '0) begin
      failures++;
      $display("FAIL async_reset: got %b/%b/%b/%b/%b/%b/%h want all zero",
               ack0, ack1, busy, done, done_id, ovf, bcd);
    end
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    checks++;
    if (ndone != 0) begin
      failures++;
      $display("FAIL discarded_done: got %0d done pulses want 0", ndone);
    end
    run_pattern(1'b1, W'(777), 1'b0, '0, 0);
    checks++;
    if (ev_id.size() != 1 || ev_bcd[0] !== 16'h0777 || ev_id[0] !== 1'b0) begin
      failures++;
      $display("FAIL reconvert_777: got %0d dones want one with bcd=0777 id=0", ev_id.size());
    end
  endtask

  task automatic test_random();
    bit            mlast;
    int            pat;
    int unsigned   a, b;
    bit            exp_id[$];
    int unsigned   exp_v[$];
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mlast = 1'b1;
    for (int it = 0; it < 14; it++) begin
      pat = (it == 0) ? 2 : int'($urandom_range(0, 2));
      a = $urandom_range(0, 2**W - 1);
      b = $urandom_range(0, 2**W - 1);
      exp_id.delete(); exp_v.delete();
      if (pat == 0) begin exp_id.push_back(1'b0); exp_v.push_back(a); mlast = 1'b0; end
      else if (pat == 1) begin exp_id.push_back(1'b1); exp_v.push_back(b); mlast = 1'b1; end
      else begin
        exp_id.push_back(!mlast); exp_v.push_back(mlast ? a : b);
        exp_id.push_back(mlast);  exp_v.push_back(mlast ? b : a);
      end
      run_pattern(pat != 1, W'(a), pat != 0, W'(b), 0);
      checks++;
      if (ev_id.size() != exp_id.size()) begin
        failures++;
        $display("FAIL rand_count[%0d]: got %0d dones want %0d", it, ev_id.size(), exp_id.size());
      end else begin
        for (int j = 0; j < exp_id.size(); j++) begin
          checks++;
          if (ev_id[j] !== exp_id[j] || ev_bcd[j] !== model_bcd(exp_v[j]) ||
              ev_ovf[j] !== model_ovf(exp_v[j]) || ev_t[j] != 15 + 16 * j) begin
            failures++;
            $display("FAIL rand_result[%0d.%0d]: got id=%b bcd=%h ovf=%b t=%0d want %b/%h/%b/%0d",
                     it, j, ev_id[j], ev_bcd[j], ev_ovf[j], ev_t[j], exp_id[j],
                     model_bcd(exp_v[j]), model_ovf(exp_v[j]), 15 + 16 * j);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_late_request();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
